// File: rtl/ir_pkg.sv
// Shared constants and the instruction word layout for the instruction queue register.
package ir_pkg;

    localparam int OPCODE_W_DEF = 4;
    localparam int DATA_W_DEF   = 4;
    localparam int DEPTH_DEF    = 4;

    localparam logic [OPCODE_W_DEF-1:0] IR_NOP = '0;

    typedef struct packed {
        logic [OPCODE_W_DEF-1:0] opcode;
        logic [DATA_W_DEF-1:0]   data;
    } ir_word_t;

endpackage

// File: rtl/ir_fifo.sv
// DEPTH x WIDTH instruction queue; occupancy is the single source of full/empty.
module ir_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale contents are unreachable once count is 0.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/instruction_queue_register.sv
// Instruction FIFO feeding a registered IR split into opcode/operand.
// Optional per-entry even-parity check enabled by defining IR_PARITY_EN.
module instruction_queue_register
    import ir_pkg::*;
#(
    parameter  int OPCODE_W = OPCODE_W_DEF,
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    localparam int INSTR_W  = OPCODE_W + DATA_W,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                instr_valid,
    input  logic [INSTR_W-1:0]  instruction,
`ifdef IR_PARITY_EN
    input  logic                instr_parity,
    output logic                parity_err,
`endif
    output logic                instr_ready,
    input  logic                load_ir,
    output logic [OPCODE_W-1:0] opcode,
    output logic [DATA_W-1:0]   data_out,
    output logic                ir_valid,
    output logic [CNT_W-1:0]    count
);

`ifdef IR_PARITY_EN
    localparam int ENTRY_W = INSTR_W + 1;
`else
    localparam int ENTRY_W = INSTR_W;
`endif

    logic [ENTRY_W-1:0]  entry_wr;
    logic [ENTRY_W-1:0]  entry_rd;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop_ok;
    logic                underrun;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                ir_valid_q, ir_valid_d;

`ifdef IR_PARITY_EN
    assign entry_wr = {instr_parity, instruction};
`else
    assign entry_wr = instruction;
`endif

    ir_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush   (flush),
        .push    (instr_valid),
        .pop     (load_ir),
        .wr_data (entry_wr),
        .rd_data (entry_rd),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign instr_ready = !fifo_full;
    // flush swallows load_ir entirely, so it is neither a pop nor an underrun.
    assign pop_ok      = load_ir && !fifo_empty && !flush;
    assign underrun    = load_ir && fifo_empty && !flush;

    always_comb begin
        opcode_d   = opcode_q;
        data_d     = data_q;
        ir_valid_d = ir_valid_q;
        if (pop_ok) begin
            {opcode_d, data_d} = entry_rd[INSTR_W-1:0];
            ir_valid_d         = 1'b1;
        end else if (underrun) begin
            ir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opcode_q   <= OPCODE_W'(IR_NOP);
            data_q     <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            opcode_q   <= opcode_d;
            data_q     <= data_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign opcode   = opcode_q;
    assign data_out = data_q;
    assign ir_valid = ir_valid_q;

`ifdef IR_PARITY_EN
    logic parity_err_q, parity_err_d;

    always_comb begin
        parity_err_d = parity_err_q;
        if (pop_ok)
            parity_err_d = (^entry_rd[INSTR_W-1:0]) != entry_rd[INSTR_W];
        else if (underrun)
            parity_err_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) parity_err_q <= 1'b0;
        else       parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`endif

endmodule
